// File: rtl/mul_product_accumulator.sv
// Multiply-accumulate back end: sums a run of 4-bit multiplier products.
// Optional saturation on overflow is enabled with `define MUL_ACC_SAT_EN.
module mul_product_accumulator #(
  parameter int ACC_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             p_valid,
  input  logic [3:0]       p_data,
  output logic             p_ready,
  output logic [ACC_W-1:0] sum,
  output logic             done,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic [ACC_W:0]   add;
  logic             carry;
  logic [ACC_W-1:0] sum_nx;

  assign p_ready = (state == ACC);
  assign done    = (state == DONE);
  assign busy    = (state == ACC) || (state == DONE);
  assign accept  = p_valid && p_ready;

  // One extra bit holds the carry that flags overflow.
  assign add   = {1'b0, sum} + {{(ACC_W-3){1'b0}}, p_data};
  assign carry = add[ACC_W];

`ifdef MUL_ACC_SAT_EN
  // Clamp to all-ones; once there, any further carry keeps it clamped.
  assign sum_nx = carry ? {ACC_W{1'b1}} : add[ACC_W-1:0];
`else
  assign sum_nx = add[ACC_W-1:0];
`endif

  // Next-state logic for the run sequencer.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (len == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (accept && (cnt == CNT_W'(1))) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register, accumulator, overflow flag and product counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sum   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if ((state == IDLE) && start) begin
        sum <= '0;
        ovf <= 1'b0;
        cnt <= len;
      end else if (accept) begin
        sum <= sum_nx;
        ovf <= ovf | carry;
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mul_product_accumulator.sv
// Self-checking bench: two accumulator widths (8 and 6) driven in lockstep
// and compared against a whole-run arithmetic model.
module tb_mul_product_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic       p_valid;
  logic [3:0] p_data;

  logic       p_ready8, done8, busy8, ovf8;
  logic [7:0] sum8;
  logic       p_ready6, done6, busy6, ovf6;
  logic [5:0] sum6;

  int ncmp = 0;
  int nerr = 0;
  int data_q[$];

  always #5 clk = ~clk;

  mul_product_accumulator #(.ACC_W(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .p_valid(p_valid), .p_data(p_data), .p_ready(p_ready8),
    .sum(sum8), .done(done8), .busy(busy8), .ovf(ovf8)
  );

  mul_product_accumulator #(.ACC_W(6), .CNT_W(4)) dut6 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .p_valid(p_valid), .p_data(p_data), .p_ready(p_ready6),
    .sum(sum6), .done(done6), .busy(busy6), .ovf(ovf6)
  );

  // Expected register contents given the exact mathematical total of a run.
  function automatic int exp_sum(input int total, input int w);
    int lim;
    lim = (1 << w);
`ifdef MUL_ACC_SAT_EN
    return (total >= lim) ? lim - 1 : total;
`else
    return total % lim;
`endif
  endfunction

  function automatic int exp_ovf(input int total, input int w);
    return (total >= (1 << w)) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sums(input string tag, input int total);
    chk({tag, "_sum8"}, 32'(sum8), exp_sum(total, 8));
    chk({tag, "_sum6"}, 32'(sum6), exp_sum(total, 6));
    chk({tag, "_ovf8"}, 32'(ovf8), exp_ovf(total, 8));
    chk({tag, "_ovf6"}, 32'(ovf6), exp_ovf(total, 6));
  endtask

  // One run over data_q; gap bubbles before every product; poke pulses
  // start mid-run and again while done is high (both must be ignored).
  task automatic run(input int n, input int gap, input bit poke);
    int total;
    int cyc;
    total = 0;
    cyc = 0;
    start = 1'b1;
    len = 4'(n);
    chk("idle_ready", 32'(p_ready8), 0);
    tick();
    cyc++;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        chk("bubble_ready", 32'(p_ready6), 1);
        chk_sums("bubble", total);
        tick();
        cyc++;
      end
      chk("acc_ready", 32'(p_ready8 & p_ready6), 1);
      chk("acc_busy", 32'(busy8), 1);
      p_valid = 1'b1;
      p_data = 4'(data_q[i]);
      if (poke && i == 1) start = 1'b1;
      tick();
      cyc++;
      p_valid = 1'b0;
      start = 1'b0;
      total += data_q[i];
      if (i != n - 1) begin
        chk("acc_done_low", 32'(done8 | done6), 0);
        chk_sums("acc", total);
      end
    end
    chk("done_pulse8", 32'(done8), 1);
    chk("done_pulse6", 32'(done6), 1);
    chk("latency", cyc, n * (gap + 1) + 1);
    chk("done_ready", 32'(p_ready8 | p_ready6), 0);
    chk("done_busy", 32'(busy8), 1);
    chk_sums("final", total);
    if (poke) begin
      start = 1'b1;
      len = 4'd3;
    end
    tick();
    start = 1'b0;
    chk("after_done", 32'(done8 | done6), 0);
    chk("after_busy", 32'(busy8 | busy6), 0);
    chk_sums("held", total);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    p_valid = 1'b0;
    p_data = '0;
    tick();
    tick();
    chk("rst_state", {sum8, 2'b0, sum6, ovf8, ovf6, done8, done6,
                      busy8, busy6, p_ready8, p_ready6}, 0);
    rst = 1'b0;
    tick();
    chk("idle_ready0", 32'(p_ready8 | p_ready6), 0);

    // Basic run: four 9s -> 36, with an ignored start mid-run and in DONE.
    data_q = {9, 9, 9, 9};
    run(4, 0, 1'b1);

    // Persistence across idle cycles.
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done8 || busy8 || sum8 != 8'd36) seen++;
    end
    chk("persist_36", seen, 0);

    // Zero-length run clears the sum and pulses done after one cycle.
    data_q = {};
    run(0, 0, 1'b0);

    // Bubbles of two cycles between products.
    data_q = {6, 4, 2};
    run(3, 2, 1'b0);

    // Overflow on the 6-bit instance: 72 wraps to 8 or clamps to 63.
    data_q = {9, 9, 9, 9, 9, 9, 9, 9};
    run(8, 0, 1'b0);

    // Randomized runs, including out-of-range products.
    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(1, 15);
      data_q = {};
      for (int i = 0; i < n; i++) begin
        data_q.push_back((r % 3 == 0) ? $urandom_range(0, 15)
                                      : $urandom_range(0, 9));
      end
      run(n, $urandom_range(0, 2), (n >= 2) && (r % 2 == 1));
      repeat ($urandom_range(0, 3)) tick();
    end

    // Reset mid-run after two of four accepts.
    data_q = {5, 7, 3, 3};
    start = 1'b1;
    len = 4'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      p_valid = 1'b1;
      p_data = 4'(data_q[i]);
      tick();
    end
    chk("pre_rst_sum", 32'(sum8), 12);
    rst = 1'b1;
    start = 1'b1;
    p_data = 4'd9;
    tick();
    rst = 1'b0;
    start = 1'b0;
    p_valid = 1'b0;
    chk("rst_mid_sum", 32'(sum8), 0);
    chk("rst_mid_busy", 32'(busy8 | busy6), 0);
    chk("rst_mid_ready", 32'(p_ready8 | p_ready6), 0);
    chk("rst_mid_ovf", 32'(ovf8 | ovf6), 0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (done8 || done6) seen++;
      tick();
    end
    chk("rst_no_done", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
